// File: rtl/result_bus_pkg.sv
// Shared constants and types for the relay-machine result bus.
// Source indices match the bus wiring order of the register side.
package result_bus_pkg;

  localparam int RESULT_BUS_WIDTH = 8;

  localparam int SRC_M   = 0;
  localparam int SRC_XY  = 1;
  localparam int SRC_J   = 2;
  localparam int SRC_PC  = 3;
  localparam int SRC_INC = 4;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_OWNED,
    BUS_LOCKED
  } bus_state_e;

endpackage

// File: rtl/result_bus_arbiter_pick.sv
// Combinational winner select: fixed priority or round robin.
// Shared with the address-bus arbiters.
module rb_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    if (rr_i) begin
      // search starts one past the last winner and wraps
      for (int k = 1; k <= N; k++) begin
        j = (int'(ptr_i) + k) % N;
        if (!found && req_i[j]) begin
          found = 1'b1;
          idx_o = IW'(j);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = IW'(i);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Arbitrated, registered result bus with lock, idle policy and
// saturating contention accounting.
module result_bus_arbiter
  import result_bus_pkg::*;
#(
  parameter int WIDTH     = RESULT_BUS_WIDTH,
  parameter int NUM_SRC   = 5,
  parameter int ARB_MODE  = ARB_FIXED,
  parameter int HOLD_IDLE = 0,
  parameter int CNT_WIDTH = 8,
  localparam int OW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     bus_lock,
  input  logic                     clr_contention,
  output logic [NUM_SRC-1:0]       src_grant,
  output logic [WIDTH-1:0]         bus_data,
  output logic                     bus_valid,
  output logic [OW-1:0]            bus_owner,
  output logic                     contention,
  output logic [CNT_WIDTH-1:0]     contention_cnt
);

  bus_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic                 cont_q, cont_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NUM_SRC-1:0] pick_gnt;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic               lock_hit;
  logic               multi;
  logic [OW-1:0]      win_idx;
  logic [WIDTH-1:0]   win_data;

  rb_pick #(
    .N  (NUM_SRC),
    .IW (OW)
  ) u_pick (
    .req_i (src_req),
    .ptr_i (ptr_q),
    .rr_i  (ARB_MODE == ARB_RR),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign lock_hit = (state_q != BUS_IDLE) && bus_lock
                    && src_req[owner_q];
  assign win_idx  = lock_hit ? owner_q : pick_idx;
  assign multi    = $countones(src_req) > 1;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == OW'(i)) win_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    if (pick_any) begin
      grant_d = lock_hit ? grant_q : pick_gnt;
      data_d  = win_data;
      owner_d = win_idx;
      state_d = bus_lock ? BUS_LOCKED : BUS_OWNED;
      if (!lock_hit) ptr_d = win_idx;
    end else begin
      grant_d = '0;
      state_d = BUS_IDLE;
      data_d  = (HOLD_IDLE != 0) ? data_q : '0;
    end
    if (clr_contention) begin
      cont_d = 1'b0;
      cnt_d  = '0;
    end else if (multi) begin
      cont_d = 1'b1;
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      grant_q <= '0;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(NUM_SRC - 1);
      cont_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src_grant      = grant_q;
  assign bus_data       = data_q;
  assign bus_valid      = (state_q != BUS_IDLE);
  assign bus_owner      = owner_q;
  assign contention     = cont_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed checks: fixed/pull-down instance A, round-robin/hold
// instance B with a 2-bit counter.
module tb_result_bus_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic [4:0]  req_a, req_b;
  logic [39:0] dat_a, dat_b;
  logic        lock_a, lock_b;
  logic        clr_a, clr_b;

  logic [4:0] gnt_a, gnt_b;
  logic [7:0] bd_a, bd_b;
  logic       bv_a, bv_b;
  logic [2:0] own_a, own_b;
  logic       ct_a, ct_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_bus_arbiter #(
    .WIDTH(8), .NUM_SRC(5), .ARB_MODE(0),
    .HOLD_IDLE(0), .CNT_WIDTH(8)
  ) dut_a (
    .clk(clk), .reset(reset),
    .src_req(req_a), .src_data(dat_a),
    .bus_lock(lock_a), .clr_contention(clr_a),
    .src_grant(gnt_a), .bus_data(bd_a),
    .bus_valid(bv_a), .bus_owner(own_a),
    .contention(ct_a), .contention_cnt(cnt_a)
  );

  result_bus_arbiter #(
    .WIDTH(8), .NUM_SRC(5), .ARB_MODE(1),
    .HOLD_IDLE(1), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .src_req(req_b), .src_data(dat_b),
    .bus_lock(lock_b), .clr_contention(clr_b),
    .src_grant(gnt_b), .bus_data(bd_b),
    .bus_valid(bv_b), .bus_owner(own_b),
    .contention(ct_b), .contention_cnt(cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] g,
                       input logic [7:0] d, input logic v,
                       input logic [2:0] o, input logic c,
                       input logic [7:0] n);
    chk({tag, ".grant"}, 32'(gnt_a), 32'(g));
    chk({tag, ".data"},  32'(bd_a),  32'(d));
    chk({tag, ".valid"}, 32'(bv_a),  32'(v));
    chk({tag, ".owner"}, 32'(own_a), 32'(o));
    chk({tag, ".cont"},  32'(ct_a),  32'(c));
    chk({tag, ".cnt"},   32'(cnt_a), 32'(n));
  endtask

  task automatic chk_b(input string tag, input logic [4:0] g,
                       input logic [7:0] d, input logic v,
                       input logic [2:0] o, input logic c,
                       input logic [1:0] n);
    chk({tag, ".grant"}, 32'(gnt_b), 32'(g));
    chk({tag, ".data"},  32'(bd_b),  32'(d));
    chk({tag, ".valid"}, 32'(bv_b),  32'(v));
    chk({tag, ".owner"}, 32'(own_b), 32'(o));
    chk({tag, ".cont"},  32'(ct_b),  32'(c));
    chk({tag, ".cnt"},   32'(cnt_b), 32'(n));
  endtask

  initial begin
    reset  = 1'b1;
    req_a  = '0; req_b  = '0;
    dat_a  = '0; dat_b  = '0;
    lock_a = 1'b0; lock_b = 1'b0;
    clr_a  = 1'b0; clr_b  = 1'b0;
    step();
    step();
    chk_a("rst_a", 5'b0, 8'h00, 0, 0, 0, 0);
    chk_b("rst_b", 5'b0, 8'h00, 0, 0, 0, 0);

    reset = 1'b0;
    step();
    chk_a("idle_a", 5'b0, 8'h00, 0, 0, 0, 0);

    // fixed priority: lowest index of 2 and 4 wins
    req_a = 5'b10100;
    dat_a[2*8 +: 8] = 8'h3C;
    dat_a[4*8 +: 8] = 8'hA5;
    step();
    chk_a("fix", 5'b00100, 8'h3C, 1, 2, 1, 1);

    // pull-down when idle
    req_a = 5'b00010;
    dat_a[1*8 +: 8] = 8'h5A;
    step();
    chk_a("drv1", 5'b00010, 8'h5A, 1, 1, 1, 1);
    req_a = 5'b00000;
    step();
    chk_a("pull", 5'b00000, 8'h00, 0, 1, 1, 1);

    // lock held by source 3 against lower-index source 0
    req_a  = 5'b01000;
    lock_a = 1'b1;
    dat_a[3*8 +: 8] = 8'h77;
    dat_a[0*8 +: 8] = 8'h11;
    step();
    chk_a("lk0", 5'b01000, 8'h77, 1, 3, 1, 1);
    req_a = 5'b01001;
    step();
    chk_a("lk1", 5'b01000, 8'h77, 1, 3, 1, 2);
    step();
    chk_a("lk2", 5'b01000, 8'h77, 1, 3, 1, 3);
    dat_a[3*8 +: 8] = 8'h78;
    step();
    chk_a("lk3", 5'b01000, 8'h78, 1, 3, 1, 4);
    req_a = 5'b00001;
    step();
    chk_a("lkdrop", 5'b00001, 8'h11, 1, 0, 1, 4);
    req_a = 5'b01001;
    step();
    chk_a("lk_own0", 5'b00001, 8'h11, 1, 0, 1, 5);

    // clear beats a simultaneous increment
    clr_a = 1'b1;
    step();
    chk_a("clr_a", 5'b00001, 8'h11, 1, 0, 0, 0);
    clr_a = 1'b0;

    // reset in the middle of a lock
    step();
    chk_a("pre_rst", 5'b00001, 8'h11, 1, 0, 1, 1);
    reset = 1'b1;
    step();
    chk_a("rst_lk", 5'b0, 8'h00, 0, 0, 0, 0);
    reset  = 1'b0;
    req_a  = '0;
    lock_a = 1'b0;

    // round robin with saturating 2-bit counter
    req_b = 5'b11111;
    for (int i = 0; i < 5; i++) dat_b[i*8 +: 8] = 8'(8'h10 + i);
    step();
    chk_b("rr0", 5'b00001, 8'h10, 1, 0, 1, 1);
    step();
    chk_b("rr1", 5'b00010, 8'h11, 1, 1, 1, 2);
    step();
    chk_b("rr2", 5'b00100, 8'h12, 1, 2, 1, 3);
    step();
    chk_b("rr3", 5'b01000, 8'h13, 1, 3, 1, 3);
    step();
    chk_b("rr4", 5'b10000, 8'h14, 1, 4, 1, 3);
    step();
    chk_b("rr5", 5'b00001, 8'h10, 1, 0, 1, 3);

    // hold last value when idle
    req_b = 5'b00010;
    dat_b[1*8 +: 8] = 8'h5A;
    step();
    chk_b("hdrv", 5'b00010, 8'h5A, 1, 1, 1, 3);
    req_b = 5'b00000;
    step();
    chk_b("hold", 5'b00000, 8'h5A, 0, 1, 1, 3);

    // pointer sits at 1: search 2,3,4,0 then 1
    req_b = 5'b00011;
    dat_b[0*8 +: 8] = 8'hC0;
    dat_b[1*8 +: 8] = 8'hC1;
    step();
    chk_b("rrw0", 5'b00001, 8'hC0, 1, 0, 1, 3);
    step();
    chk_b("rrw1", 5'b00010, 8'hC1, 1, 1, 1, 3);
    clr_b = 1'b1;
    step();
    chk_b("clr_b", 5'b00001, 8'hC0, 1, 0, 0, 0);
    clr_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
